// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Parametrised asynchronous serial receiver. Samples an idle-high serial
// line through a 2-flop synchroniser, validates the start bit at mid-bit,
// shifts in DATA_BITS data bits LSB-first, optionally checks a parity bit,
// checks the stop bit and presents the received word with a one-cycle strobe.
//
// Optional feature macro:
//   UART_RX_PARITY_EN  - when defined, a parity bit follows the data bits
//                        (even when PARITY_ODD=0, odd when PARITY_ODD=1) and
//                        parity_err is live. When undefined, the frame has
//                        no parity bit, parity_err is tied to 0 and
//                        PARITY_ODD has no effect.
//
// Parameters:
//   DATA_BITS     data bits per frame (5..9)
//   CLKS_PER_BIT  clk cycles per bit period (>= 4)
//   PARITY_ODD    0 = even parity, 1 = odd parity
//
// Ports:
//   clk         single clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   in          serial line, idle high, asynchronous to clk
//   out         last received word, holds until the next frame completes
//   valid       one-cycle strobe when out/frame_err/parity_err update
//   frame_err   stop bit sampled low (qualified by valid, held until next)
//   parity_err  parity mismatch (qualified by valid, held until next)
//   busy        high in any state other than IDLE
//   dbg_state   current FSM state encoding, for checkers
//
// Handshake: valid is a pure strobe with no ready. The consumer must capture
// out/frame_err/parity_err in the cycle valid is high (they also hold until
// the next strobe, roughly one frame time later).
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in,
    output logic [DATA_BITS-1:0] out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    // Sample points: mid start bit after H cycles, then every full period.
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                state;
    state_t                state_next;

    logic                  sync1;
    logic                  rx_s;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DATA_BITS-1:0]  shreg;
    logic                  half_hit;
    logic                  full_hit;
    logic                  stop_done;

    // -----------------------------------------------------------------------
    // Synchroniser. Resets to 1 so a reset release never looks like a start.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= in;
            rx_s  <= sync1;
        end
    end

    assign half_hit  = (cnt == HALF_M1);
    assign full_hit  = (cnt == FULL_M1);
    assign stop_done = (state == S_STOP) && full_hit;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                // A line that is high again at mid start bit was a glitch.
                if (half_hit) begin
                    state_next = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (full_hit && (idx == LAST_IDX)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
            S_PARITY: begin
                if (full_hit) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                // A low stop bit may be a break; wait for the line to recover
                // so the held-low line is not mistaken for a new start bit.
                if (full_hit) begin
                    state_next = rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Bit-period counter: wraps to 0 at every sample point.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case (state)
                S_START: begin
                    cnt <= half_hit ? '0 : cnt + CW'(1);
                end
                S_DATA, S_PARITY, S_STOP: begin
                    cnt <= full_hit ? '0 : cnt + CW'(1);
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Data shift register and bit index. Bits enter at the MSB and move
    // down, so after DATA_BITS samples the first (LSB) bit sits at bit 0.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            shreg <= '0;
        end else begin
            if (state == S_START) begin
                idx <= '0;
            end else if ((state == S_DATA) && full_hit) begin
                idx   <= idx + IW'(1);
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output word, strobe and framing status, all loaded on the stop sample.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid <= stop_done;
            if (stop_done) begin
                out       <= shreg;
                frame_err <= ~rx_s;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity bit is captured in PARITY and judged together with the data
    // at the stop sample, so parity_err updates in step with valid.
    logic par_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if ((state == S_PARITY) && full_hit) begin
                par_bit <= rx_s;
            end
            if (stop_done) begin
                parity_err <= ((^shreg) ^ par_bit) != 1'(PARITY_ODD);
            end
        end
    end
`else
    // Without a parity bit there is nothing to check; PARITY_ODD is inert.
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
    assign parity_err        = 1'b0;
`endif

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule
